// File: rtl/diagnostics_snapshot_buffer.sv
// Diagnostics snapshot buffer.
// Keeps a shadow copy of the live channel values and freezes it on request.
// The snapshot is read back one byte at a time: byte 0 is the snapshot
// count, byte 1 is status, and the channel bytes follow, MS byte first.
module diagnostics_snapshot_buffer #(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] channel_data,
  input  logic                                  freeze,
  input  logic                                  capture_req,
  input  logic                                  release_req,
  input  logic                                  read_start,
  input  logic [ADDR_WIDTH-1:0]                 read_addr,
  input  logic                                  read_next,
  output logic [7:0]                            read_data,
  output logic                                  read_valid,
  output logic                                  frozen,
  output logic [7:0]                            seq_count,
  output logic                                  overrun
);

  localparam int unsigned BPC         = CHANNEL_WIDTH / 8;
  localparam int unsigned CH_BYTES    = NUM_CHANNELS * BPC;
  localparam int unsigned TOTAL_BYTES = 2 + CH_BYTES;
  localparam int unsigned DATA_W      = NUM_CHANNELS * CHANNEL_WIDTH;

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t                  state;
  logic                    hold;
  logic [DATA_W-1:0]       shadow;
  logic [ADDR_WIDTH-1:0]   ptr;

  logic [ADDR_WIDTH-1:0]   next_ptr_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [7:0]              sel_byte_c;
  logic                    load_c;

  // Snapshot state machine: shadow tracking, hold flag and snapshot count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LIVE;
      hold      <= 1'b0;
      shadow    <= '0;
      seq_count <= 8'h00;
      frozen    <= 1'b0;
    end else begin
      // capture_req beats release_req when both arrive together
      if (capture_req) begin
        hold <= 1'b1;
      end else if (release_req) begin
        hold <= 1'b0;
      end
      case (state)
        LIVE: begin
          shadow <= channel_data;
          if (freeze || capture_req) begin
            state     <= FROZEN;
            frozen    <= 1'b1;
            seq_count <= seq_count + 8'd1;
          end
        end
        FROZEN: begin
          // Leave only when nothing is holding the snapshot after this edge
          if (!freeze && !capture_req && (!hold || release_req)) begin
            state  <= LIVE;
            frozen <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read address selection and byte map lookup
  always_comb begin
    next_ptr_c = '0;
    sel_addr_c = '0;
    sel_byte_c = 8'h00;
    load_c     = read_start | read_next;

    // Out-of-range pointers also wrap to 0
    if (32'(ptr) >= TOTAL_BYTES - 1) begin
      next_ptr_c = '0;
    end else begin
      next_ptr_c = ptr + ADDR_WIDTH'(1);
    end

    sel_addr_c = read_start ? read_addr : next_ptr_c;

    if (32'(sel_addr_c) == 32'd0) begin
      sel_byte_c = seq_count;
    end else if (32'(sel_addr_c) == 32'd1) begin
      sel_byte_c = {overrun, 6'b000000, frozen};
    end
    for (int unsigned i = 0; i < CH_BYTES; i++) begin
      if (32'(sel_addr_c) == i + 2) begin
        sel_byte_c = shadow[(i / BPC) * CHANNEL_WIDTH + (BPC - 1 - (i % BPC)) * 8 +: 8];
      end
    end
  end

  // Read pointer and registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      read_data  <= 8'h00;
      read_valid <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      if (load_c) begin
        ptr        <= sel_addr_c;
        read_data  <= sel_byte_c;
        read_valid <= 1'b1;
      end
    end
  end

  // Sticky overrun; cleared when the status byte is read out, a new set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((state == FROZEN) && capture_req) begin
      overrun <= 1'b1;
    end else if (load_c && (32'(sel_addr_c) == 32'd1)) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diagnostics_snapshot_buffer.sv
// Directed bench for diagnostics_snapshot_buffer (8 channels x 16 bits).
module tb_diagnostics_snapshot_buffer;

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned AW  = 8;

  logic              clk;
  logic              reset_n;
  logic [NCH*CW-1:0] channel_data;
  logic              freeze;
  logic              capture_req;
  logic              release_req;
  logic              read_start;
  logic [AW-1:0]     read_addr;
  logic              read_next;
  logic [7:0]        read_data;
  logic              read_valid;
  logic              frozen;
  logic [7:0]        seq_count;
  logic              overrun;

  int tests_run;
  int tests_failed;

  diagnostics_snapshot_buffer #(
    .NUM_CHANNELS (NCH),
    .CHANNEL_WIDTH(CW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .channel_data(channel_data),
    .freeze      (freeze),
    .capture_req (capture_req),
    .release_req (release_req),
    .read_start  (read_start),
    .read_addr   (read_addr),
    .read_next   (read_next),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .frozen      (frozen),
    .seq_count   (seq_count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] val);
    channel_data[k*CW +: CW] = val;
  endtask

  task automatic check_read(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(read_valid), 32'd1);
    check({tag, "_data"}, 32'(read_data), 32'(exp));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    channel_data = '0;
    freeze       = 1'b0;
    capture_req  = 1'b0;
    release_req  = 1'b0;
    read_start   = 1'b0;
    read_addr    = '0;
    read_next    = 1'b0;

    // Reset values
    #2;
    check("rst_read_data", 32'(read_data), 32'h00);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_frozen", 32'(frozen), 32'd0);
    check("rst_seq", 32'(seq_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    set_ch(0, 16'h1234);
    set_ch(1, 16'hABCD);
    tick();
    tick();

    // Capture, then change inputs and read channel bytes 2..5
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    check("cap_frozen", 32'(frozen), 32'd1);
    check("cap_seq", 32'(seq_count), 32'd1);
    set_ch(0, 16'h5566);
    set_ch(1, 16'h0000);
    read_start = 1'b1;
    read_addr  = 8'd2;
    tick();
    read_start = 1'b0;
    check_read("rd_b2", 8'h12);
    read_next = 1'b1;
    tick();
    check_read("rd_b3", 8'h34);
    tick();
    check_read("rd_b4", 8'hAB);
    tick();
    check_read("rd_b5", 8'hCD);
    read_next = 1'b0;
    tick();
    check("idle_valid", 32'(read_valid), 32'd0);
    check("idle_hold_data", 32'(read_data), 32'hCD);
    check("hold_frozen", 32'(frozen), 32'd1);
    check("hold_seq", 32'(seq_count), 32'd1);

    // capture_req while frozen sets overrun; status read clears it
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_seq_unchanged", 32'(seq_count), 32'd1);
    read_start = 1'b1;
    read_addr  = 8'd1;
    tick();
    check_read("status_first", 8'h81);
    check("ovr_cleared", 32'(overrun), 32'd0);
    tick();
    check_read("status_second", 8'h01);
    read_addr = 8'd0;
    tick();
    check_read("byte0_seq", 8'h01);
    read_start = 1'b0;

    // Release returns to LIVE; shadow tracks from the following edge
    release_req = 1'b1;
    tick();
    release_req = 1'b0;
    check("rel_frozen", 32'(frozen), 32'd0);
    tick();
    read_start = 1'b1;
    read_addr  = 8'd2;
    tick();
    read_start = 1'b0;
    check_read("live_b2", 8'h55);

    // freeze level for 5 edges
    set_ch(7, 16'h9A5C);
    freeze = 1'b1;
    tick();
    check("frz_1", 32'(frozen), 32'd1);
    set_ch(0, 16'h7788);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_n", 32'(frozen), 32'd1);
    end
    freeze = 1'b0;
    tick();
    check("frz_exit", 32'(frozen), 32'd0);
    check("frz_seq", 32'(seq_count), 32'd2);
    read_start = 1'b1;
    read_addr  = 8'd2;
    tick();
    check_read("frz_held_b2", 8'h55);
    tick();
    check_read("resume_b2", 8'h77);

    // Last byte, wrap, out of range, start/next collision
    read_addr = 8'd17;
    tick();
    check_read("b17", 8'h5C);
    read_start = 1'b0;
    read_next  = 1'b1;
    tick();
    check_read("wrap_b0", 8'h02);
    read_next  = 1'b0;
    read_start = 1'b1;
    read_addr  = 8'd200;
    tick();
    check_read("oor_200", 8'h00);
    read_start = 1'b0;
    read_next  = 1'b1;
    tick();
    check_read("oor_wrap", 8'h02);
    read_start = 1'b1;
    read_addr  = 8'd3;
    tick();
    check_read("start_wins", 8'h88);
    read_start = 1'b0;
    read_next  = 1'b0;

    // 256 capture/release pairs: seq_count wraps
    for (int i = 0; i < 256; i++) begin
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
      release_req = 1'b1;
      tick();
      release_req = 1'b0;
      tick();
      if (i == 253) check("seq_wrap0", 32'(seq_count), 32'd0);
    end
    check("seq_after_256", 32'(seq_count), 32'd2);
    check("pairs_live", 32'(frozen), 32'd0);

    // Same-cycle capture+release while frozen keeps hold and sets overrun
    capture_req = 1'b1;
    tick();
    release_req = 1'b1;
    tick();
    capture_req = 1'b0;
    release_req = 1'b0;
    tick();
    check("both_frozen", 32'(frozen), 32'd1);
    check("both_overrun", 32'(overrun), 32'd1);
    check("both_seq", 32'(seq_count), 32'd3);

    // Reset during frozen readout
    read_start = 1'b1;
    read_addr  = 8'd2;
    tick();
    read_start = 1'b0;
    check_read("pre_rst_b2", 8'h77);
    read_next = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(read_data), 32'h00);
    check("mid_rst_valid", 32'(read_valid), 32'd0);
    check("mid_rst_frozen", 32'(frozen), 32'd0);
    check("mid_rst_seq", 32'(seq_count), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    read_next = 1'b0;
    set_ch(0, 16'h4242);
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_frozen", 32'(frozen), 32'd0);
    read_start = 1'b1;
    read_addr  = 8'd2;
    tick();
    read_start = 1'b0;
    check_read("post_rst_b2", 8'h42);
    check("post_rst_seq", 32'(seq_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
